regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Round-robin arbiter and access sequencer for the 8 x 16-bit register file. It shares the file's single read path (the 8:1 16-bit read multiplexer) and its write port among NREQ requesters. It drives the multiplexer select, captures the selected word and returns it to the granted requester. It also issues write strobes, and serializes all accesses so only one is in flight at a time.

## Interface
- NREQ, 4, number of requesters (2..8)
- DATA_W, 16, register width
- ADDR_W, 3, register index width (8 registers)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*ADDR_W  register index, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-cycle read-response pulse to the owning requester
- rsp_data  out  DATA_W  read data, valid while any rsp_valid bit is high
- rf_sel  out  ADDR_W  read-multiplexer select
- rf_rdata  in  DATA_W  multiplexer output (combinational from rf_sel)
- rf_we  out  1  register-file write strobe
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- busy  out  1  high in ISSUE state

## Operation
- FSM states: IDLE, ISSUE.
  - IDLE -> ISSUE on any handshake.
  - ISSUE -> IDLE unconditionally after one cycle.
- Round-robin pointer `ptr`, range 0..NREQ-1, reset 0.
  - In IDLE, grant the first i with req_valid[i], scanning ptr, ptr+1, … modulo NREQ.
  - req_ready is combinational: one-hot on the winner in IDLE, all-zero in ISSUE and during reset.
  - On handshake with requester i, ptr <= (i+1) mod NREQ. With no handshake, ptr holds.
- On handshake, latch owner index, op, address and wdata. For a read, rf_sel <= addr. For a write, rf_waddr/rf_wdata <= addr/wdata and rf_we <= 1.
- ISSUE, read:
  - rf_sel is stable for the whole cycle.
  - At the end of the cycle, rsp_data <= rf_rdata and rsp_valid[owner] <= 1.
- ISSUE, write:
  - rf_we is high for exactly this cycle; the register file commits at the end of it.
  - rf_we <= 0 at the end of the cycle. No response is generated for writes.
- rsp_valid is a pulse with no backpressure; requesters must accept it.
- rsp_data holds its last value until the next read response.
- rf_sel, rf_waddr and rf_wdata hold their last value when not updated.
- Requester rules:
  - req_valid must not depend on req_ready.
  - Once raised, req_valid and its payload stay stable until the handshake.
  - Behaviour on a violation is undefined.
- Simultaneous response pulse and new grant: legal. In the cycle after ISSUE, rsp_valid pulses and IDLE may grant again in the same cycle.
- Reset mid-operation: state -> IDLE, in-flight access dropped, rf_we and rsp_valid forced low immediately (asynchronously).

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, rf_sel 0, rf_we 0, rf_waddr 0, rf_wdata 0, busy 0, ptr 0, state IDLE.
- Read: handshake in cycle N -> rf_sel = addr and busy = 1 in N+1 -> rsp_valid[i] = 1 with rsp_data in N+2 (2-cycle latency).
- Write: handshake in N -> rf_we = 1 in N+1 -> new value readable via rf_sel from N+2.
- Throughput: at most one access every 2 cycles, so next grant no earlier than N+2.
- Read after write to the same register is always ordered, because accesses are serialized.
- Grant fairness: a continuously valid requester is granted within NREQ grants.

## Test plan
- Reset: rst_n low mid-ISSUE with a read to reg 5 -> rsp_valid stays 0 and rf_we is 0 immediately; after release, ptr = 0 and outputs are at reset values.
- Single write then read:
  - Requester 2 writes 0xBEEF to reg 6 in cycle N -> rf_we = 1, rf_waddr = 6, rf_wdata = 0xBEEF in N+1.
  - Requester 2 then reads reg 6 (accepted at N+2) -> rf_sel = 6 in N+3, rsp_valid = 4'b0100 and rsp_data = 0xBEEF in N+4.
- Round-robin: all 4 requesters hold reads of regs 0..3 -> grants in order 0,1,2,3,0 on cycles N, N+2, N+4, N+6, N+8; each rsp_data matches its register.
- Pointer wrap: ptr = 3, requesters 0 and 3 valid -> requester 3 granted, then requester 0, with ptr = 1 afterwards.
- Back-to-back: a read response pulse in cycle M coincides with the next grant in M -> both observed in M; no lost or duplicated pulse.
- Stability: in ISSUE, toggling req_addr of a waiting requester -> req_ready stays 0 and rf_sel does not change.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter: request handshake,
// write payload and read-response return path, bundled per requester.
interface regfile_port_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that serializes read/write accesses of NREQ requesters
// onto the register file's single read mux and write port.
module regfile_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]     rf_sel,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  busy
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [PTR_W-1:0]    owner_r;
    logic                op_we_r;
    logic [NREQ-1:0]     rsp_valid_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic [ADDR_W-1:0]   rf_sel_r;
    logic                rf_we_r;
    logic [ADDR_W-1:0]   rf_waddr_r;
    logic [DATA_W-1:0]   rf_wdata_r;

    logic [NREQ-1:0]     grant_s;
    logic [PTR_W-1:0]    win_s;
    logic                found_s;
    logic                win_we_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_wdata_s;
    logic                idle_s;
    logic                hs_s;
    logic [PTR_W-1:0]    nxt_ptr_s;

    // Round-robin scan starting at ptr_r; the first valid requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_s     = {NREQ{1'b0}};
        win_s       = {PTR_W{1'b0}};
        found_s     = 1'b0;
        win_we_s    = 1'b0;
        win_addr_s  = {ADDR_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_r) + k) % NREQ;
            if (!found_s && bus.req_valid[idx]) begin
                found_s      = 1'b1;
                grant_s[idx] = 1'b1;
                win_s        = PTR_W'(idx);
                win_we_s     = bus.req_we[idx];
                win_addr_s   = bus.req_addr[idx*ADDR_W +: ADDR_W];
                win_wdata_s  = bus.req_wdata[idx*DATA_W +: DATA_W];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idle_s    = (state_r == IDLE);
    assign hs_s      = idle_s & found_s;
    assign nxt_ptr_s = (win_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : win_s + PTR_W'(1);

    // Grant is only offered while idle and out of reset.
    assign bus.req_ready = (idle_s && rst_n) ? grant_s : {NREQ{1'b0}};
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign rf_sel        = rf_sel_r;
    assign rf_we         = rf_we_r;
    assign rf_waddr      = rf_waddr_r;
    assign rf_wdata      = rf_wdata_r;
    assign busy          = (state_r == ISSUE);

    // Access sequencer: latch the winner on handshake, perform it in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {PTR_W{1'b0}};
            owner_r     <= {PTR_W{1'b0}};
            op_we_r     <= 1'b0;
            rsp_valid_r <= {NREQ{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            rf_sel_r    <= {ADDR_W{1'b0}};
            rf_we_r     <= 1'b0;
            rf_waddr_r  <= {ADDR_W{1'b0}};
            rf_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= {NREQ{1'b0}};
                    if (hs_s) begin
                        state_r <= ISSUE;
                        ptr_r   <= nxt_ptr_s;
                        owner_r <= win_s;
                        op_we_r <= win_we_s;
                        if (win_we_s) begin
                            rf_waddr_r <= win_addr_s;
                            rf_wdata_r <= win_wdata_s;
                            rf_we_r    <= 1'b1;
                        end else begin
                            rf_sel_r <= win_addr_s;
                            rf_we_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                        rf_we_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_r <= IDLE;
                    rf_we_r <= 1'b0;
                    // Reads capture the mux output while rf_sel is settled.
                    if (!op_we_r) begin
                        rsp_data_r  <= rf_rdata;
                        rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
                    end else begin
                        rsp_valid_r <= {NREQ{1'b0}};
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rf_we_r     <= 1'b0;
                    rsp_valid_r <= {NREQ{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: randomized requesters, a
// behavioural arbitration/memory model and a decoupled response monitor.
module tb_regfile_port_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam logic [15:0] INIT [8] = '{16'h0A00, 16'h1B11, 16'h2C22, 16'h3D33,
                                         16'h4E44, 16'h5F55, 16'h6066, 16'h7177};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic [ADDR_W-1:0] rf_sel, rf_waddr;
    logic [DATA_W-1:0] rf_rdata, rf_wdata;
    logic              rf_we, busy;

    regfile_port_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rf_sel(rf_sel), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    // Environment register file driven only by the DUT's strobes
    logic [15:0] env_rf [8] = INIT;
    assign rf_rdata = env_rf[rf_sel];
    always @(posedge clk) if (rf_we) env_rf[rf_waddr] <= rf_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct { int req; logic [15:0] data; int cyc; } rd_t;
    typedef struct { logic [2:0] addr; logic [15:0] data; int cyc; } wr_t;
    rd_t rdq[$];
    wr_t wrq[$];

    // Reference model state
    logic [15:0] m_mem [8];
    int          mptr = 0;
    int          m_last_hs = -10;
    logic [2:0]  m_sel = 3'd0, m_waddr = 3'd0;
    logic [15:0] m_wdata = 16'h0, last_rsp = 16'h0;

    // Requester state
    bit          pend [NREQ];
    bit          p_we [NREQ];
    logic [2:0]  p_addr [NREQ];
    logic [15:0] p_wdata [NREQ];

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i]) begin
                p_addr[i]  = 3'($urandom_range(0, 7));
                p_wdata[i] = 16'($urandom);
                p_we[i]    = 1'($urandom_range(0, 1));
            end
            bus.req_valid[i]                = pend[i];
            bus.req_we[i]                   = p_we[i];
            bus.req_addr[i*ADDR_W +: ADDR_W] = p_addr[i];
            bus.req_wdata[i*DATA_W +: DATA_W] = p_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [2:0] a, input logic [15:0] d);
        pend[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wdata[i] = d;
        drive();
    endtask

    task automatic model_reset();
        mptr = 0; m_last_hs = -10; m_sel = 3'd0; m_waddr = 3'd0;
        m_wdata = 16'h0; last_rsp = 16'h0;
        rdq.delete(); wrq.delete();
    endtask

    // One cycle: predict and check the grant at negedge, then update requesters
    task automatic step(input bit rnd);
        logic [NREQ-1:0] vv, act_rdy, exp_rdy;
        bit in_issue;
        int w;
        @(negedge clk);
        vv       = bus.req_valid;
        act_rdy  = bus.req_ready;
        in_issue = (cyc == m_last_hs + 1);
        w = -1;
        if (!in_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && vv[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", act_rdy, exp_rdy);
        chk("busy", busy, in_issue);
        chk("rf_sel", rf_sel, m_sel);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        if (w >= 0) begin
            m_last_hs = cyc;
            mptr = (w + 1) % NREQ;
            if (p_we[w]) begin
                wrq.push_back('{addr: p_addr[w], data: p_wdata[w], cyc: cyc + 1});
                m_mem[p_addr[w]] = p_wdata[w];
                m_waddr = p_addr[w];
                m_wdata = p_wdata[w];
            end else begin
                rdq.push_back('{req: w, data: m_mem[p_addr[w]], cyc: cyc + 2});
                m_sel = p_addr[w];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (act_rdy[i] && vv[i]) pend[i] = 1'b0;
            if (rnd && !pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response or strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid != '0) begin
                if (rdq.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 32'h0);
                end else begin
                    rd_t e;
                    e = rdq.pop_front();
                    chk("rsp_valid", bus.rsp_valid, 32'(1) << e.req);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_cycle", cyc, e.cyc);
                    last_rsp = e.data;
                end
            end else begin
                chk("rsp_data_hold", bus.rsp_data, last_rsp);
                if (rdq.size() > 0 && rdq[0].cyc < cyc) begin
                    chk("rsp_missing", cyc, rdq[0].cyc);
                    void'(rdq.pop_front());
                end
            end
            if (rf_we) begin
                if (wrq.size() == 0) begin
                    chk("rf_we_unexpected", rf_we, 32'h0);
                end else begin
                    wr_t e;
                    e = wrq.pop_front();
                    chk("wr_addr", rf_waddr, e.addr);
                    chk("wr_data", rf_wdata, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else if (wrq.size() > 0 && wrq[0].cyc < cyc) begin
                chk("wr_missing", cyc, wrq[0].cyc);
                void'(wrq.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = INIT[i];
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        rst_n = 1'b0;
        pend[1] = 1'b1;
        drive();
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_rf_sel", rf_sel, 32'h0);
        chk("rst_rf_we", rf_we, 32'h0);
        chk("rst_rf_waddr", rf_waddr, 32'h0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_busy", busy, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(3);

        // Write 0xBEEF to reg 6 from requester 2, then read it back
        set_req(2, 1'b1, 3'd6, 16'hBEEF);
        run(3);
        set_req(2, 1'b0, 3'd6, 16'h0000);
        run(4);

        // All four requesters read regs 0..3 simultaneously
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'(i), 16'h0);
        run(10);

        // Pointer wrap: grant 2 so ptr is 3, then requesters 0 and 3 contend
        set_req(2, 1'b0, 3'd7, 16'h0);
        run(3);
        set_req(0, 1'b0, 3'd1, 16'h0);
        set_req(3, 1'b0, 3'd6, 16'h0);
        run(6);

        // Reset in the middle of a read of reg 5
        set_req(1, 1'b0, 3'd5, 16'h0);
        step(1'b0);
        set_req(3, 1'b1, 3'd2, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 32'h0);
        chk("midrst_rf_we", rf_we, 32'h0);
        chk("midrst_req_ready", bus.req_ready, 32'h0);
        chk("midrst_busy", busy, 32'h0);
        chk("midrst_rf_sel", rf_sel, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(4);

        // Randomized traffic
        repeat (600) step(1'b1);

        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        run(6);
        chk("rdq_drained", rdq.size(), 32'h0);
        chk("wrq_drained", wrq.size(), 32'h0);
        for (int i = 0; i < 8; i++) chk("final_mem", env_rf[i], m_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
